// File: rtl/regfile_write_arbiter_if.sv
// Writeback bus shared by N requesters and the register file write port.
// Requesters drive req_*; the arbiter drives ready and the registered write port.
interface regfile_write_arbiter_if #(
    parameter int N_REQ  = 3,
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
);
    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ-1:0]        req_last;
    logic [N_REQ*ADDR_W-1:0] req_addr;
    logic [N_REQ*DATA_W-1:0] req_data;
    logic [N_REQ-1:0]        req_ready;
    logic                    rf_we;
    logic [ADDR_W-1:0]       rf_a3;
    logic [DATA_W-1:0]       rf_wd3;
    logic [2**ADDR_W-1:0]    hazard_mask;
    logic                    burst_abort;
    logic [7:0]              drop_cnt;

    modport master (
        output req_valid, req_last, req_addr, req_data,
        input  req_ready, rf_we, rf_a3, rf_wd3,
        input  hazard_mask, burst_abort, drop_cnt
    );

    modport slave (
        input  req_valid, req_last, req_addr, req_data,
        output req_ready, rf_we, rf_a3, rf_wd3,
        output hazard_mask, burst_abort, drop_cnt
    );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter for the register file write port with burst lock,
// idle-timeout abort, registered write stage, hazard mask and $0 drop counter.
module regfile_write_arbiter #(
    parameter int N_REQ     = 3,
    parameter int ADDR_W    = 5,
    parameter int DATA_W    = 32,
    parameter int BURST_TMO = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    regfile_write_arbiter_if.slave bus
);
    localparam int IDX_W  = $clog2(N_REQ);
    localparam int CNT_W  = $clog2(BURST_TMO) + 1;
    localparam int MASK_W = 2**ADDR_W;

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_BURST = 1'b1;

    logic [0:0]        r_state;
    logic [IDX_W-1:0]  r_rr_ptr;
    logic [IDX_W-1:0]  r_owner;
    logic [CNT_W-1:0]  r_idle;
    logic              r_we;
    logic [ADDR_W-1:0] r_a3;
    logic [DATA_W-1:0] r_wd3;
    logic              r_abort;
    logic [7:0]        r_drop;

    logic              w_found;
    logic [IDX_W-1:0]  w_win;
    logic [IDX_W-1:0]  w_sel;
    logic              w_xfer;
    logic              w_last;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_data;
    logic [IDX_W-1:0]  w_next_rr;
    logic [N_REQ-1:0]  w_ready;
    logic [MASK_W-1:0] w_mask;

    function automatic logic [IDX_W-1:0] f_wrap(input int j);
        if (j >= N_REQ) return IDX_W'(j - N_REQ);
        return IDX_W'(j);
    endfunction

    // First valid requester at or after rr_ptr, wrapping around.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (!w_found && bus.req_valid[f_wrap(int'(r_rr_ptr) + k)]) begin
                w_found = 1'b1;
                w_win   = f_wrap(int'(r_rr_ptr) + k);
            end
        end
    end

    assign w_sel  = (r_state == S_BURST) ? r_owner : w_win;
    assign w_xfer = (r_state == S_BURST) ? bus.req_valid[w_sel] : w_found;

    always_comb begin
        w_ready = '0;
        if (r_state == S_BURST || w_found) w_ready[w_sel] = 1'b1;
    end

    always_comb begin
        w_addr = '0;
        w_data = '0;
        w_last = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_sel == IDX_W'(i)) begin
                w_addr = bus.req_addr[i*ADDR_W +: ADDR_W];
                w_data = bus.req_data[i*DATA_W +: DATA_W];
                w_last = bus.req_last[i];
            end
        end
    end

    assign w_next_rr = (w_sel == IDX_W'(N_REQ - 1)) ? '0 : w_sel + IDX_W'(1);
    assign w_mask    = r_we ? (MASK_W'(1) << r_a3) : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_rr_ptr <= '0;
            r_owner  <= '0;
            r_idle   <= '0;
            r_we     <= 1'b0;
            r_a3     <= '0;
            r_wd3    <= '0;
            r_abort  <= 1'b0;
            r_drop   <= '0;
        end else begin
            r_we    <= 1'b0;
            r_abort <= 1'b0;
            // Beats to $0 are consumed but never reach the register file.
            if (w_xfer) begin
                if (w_addr != '0) begin
                    r_we  <= 1'b1;
                    r_a3  <= w_addr;
                    r_wd3 <= w_data;
                end else if (r_drop != 8'hFF) begin
                    r_drop <= r_drop + 8'd1;
                end
            end
            case (r_state)
                S_IDLE: begin
                    if (w_xfer) begin
                        if (w_last) begin
                            r_rr_ptr <= w_next_rr;
                        end else begin
                            r_state <= S_BURST;
                            r_owner <= w_sel;
                            r_idle  <= '0;
                        end
                    end
                end
                S_BURST: begin
                    if (w_xfer) begin
                        if (w_last) begin
                            r_state  <= S_IDLE;
                            r_rr_ptr <= w_next_rr;
                        end else begin
                            r_idle <= '0;
                        end
                    end else if (r_idle == CNT_W'(BURST_TMO - 1)) begin
                        r_state  <= S_IDLE;
                        r_rr_ptr <= w_next_rr;
                        r_abort  <= 1'b1;
                    end else begin
                        r_idle <= r_idle + CNT_W'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.req_ready   = w_ready;
    assign bus.rf_we       = r_we;
    assign bus.rf_a3       = r_a3;
    assign bus.rf_wd3      = r_wd3;
    assign bus.hazard_mask = w_mask;
    assign bus.burst_abort = r_abort;
    assign bus.drop_cnt    = r_drop;
endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
- Shares the register file's single write port (we, A3, WD3) among N writeback requesters, e.g. ALU writeback, load unit and debug/monitor injector.
- Round-robin arbitration with valid/ready handshake.
- Optional multi-beat bursts that lock the port to one requester, protected by an idle timeout.
- Registered write stage drives the register file directly; it also exports a hazard mask and a counter of discarded writes to $0.

Parameters:
N_REQ, 3, number of requesters (2..8)
ADDR_W, 5, register address width
DATA_W, 32, write data width
BURST_TMO, 16, consecutive idle owner cycles before a burst is aborted (>=1)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
req_valid  input  N_REQ  per-requester write request
req_last  input  N_REQ  final beat of the requester's burst; 1 on every beat for single writes
req_addr  input  N_REQ*ADDR_W  packed destination addresses, requester i at bits [i*ADDR_W +: ADDR_W]
req_data  input  N_REQ*DATA_W  packed write data, same packing
req_ready  output  N_REQ  one-hot-or-zero accept; transfer = valid & ready
rf_we  output  1  register file write enable
rf_a3  output  ADDR_W  register file write address
rf_wd3  output  DATA_W  register file write data
hazard_mask  output  2**ADDR_W  one-hot of rf_a3 when rf_we=1, else 0
burst_abort  output  1  one-cycle pulse when a burst times out
drop_cnt  output  8  saturating count of accepted writes to address 0

Behaviour:
- Reset (async assert, sync release) clears the following:
  - rf_we, rf_a3, rf_wd3, burst_abort, drop_cnt all 0; hazard_mask 0.
  - rr_ptr=0, owner=0, idle counter 0, state IDLE.
- Reset mid-burst or with a write staged discards it: rf_we drops immediately, no write reaches the register file.
- States: IDLE, BURST.
- IDLE grant:
  - req_ready is combinational.
  - The winner is the first valid requester scanning rr_ptr, rr_ptr+1, ... mod N_REQ.
  - Only the winner's ready is high; all ready bits are 0 if no valid.
- BURST grant:
  - req_ready[owner] = 1 regardless of valid; all other ready bits are 0.
- Write stage (1-cycle latency):
  - On transfer, the next edge loads rf_a3/rf_wd3 from the winner and sets rf_we=1, except when the address is 0.
  - If the address is 0: rf_we=0, the beat is still consumed and drop_cnt increments, saturating at 255.
  - No transfer: rf_we=0 next cycle; rf_a3/rf_wd3 hold their last value.
  - Back-to-back transfers produce rf_we=1 on consecutive cycles.
- Transitions:
  - IDLE, transfer by winner w with last=1: stay IDLE, rr_ptr <= (w+1) mod N_REQ.
  - IDLE, transfer by winner w with last=0: go to BURST, owner <= w, idle counter <= 0; rr_ptr unchanged.
  - BURST, owner transfer with last=0: stay, idle counter <= 0.
  - BURST, owner transfer with last=1: go to IDLE, rr_ptr <= (owner+1) mod N_REQ.
  - BURST, owner valid=0: idle counter increments.
  - BURST, idle counter reaches BURST_TMO-1 with valid still 0 (i.e. BURST_TMO consecutive idle cycles): next cycle state=IDLE, rr_ptr <= (owner+1) mod N_REQ, burst_abort=1 for exactly one cycle.
  - Beats already written before an abort are not undone.
- Requesters must hold valid/addr/data/last stable until accepted; the arbiter never grants a non-valid requester in IDLE.
- Simultaneous valid from all requesters: strict rotation. No requester waits more than N_REQ-1 single-write grants.
- hazard_mask is derived combinationally from the registered rf_we/rf_a3. Downstream decode compares it against the read addresses for stall/forward decisions.

Test Plan:
- Single write: req0 valid, addr=8, data=0xDEADBEEF, last=1 -> ready0 same cycle; next cycle rf_we=1, rf_a3=8, rf_wd3=0xDEADBEEF, hazard_mask bit 8 only; following cycle rf_we=0.
- Round-robin: all three valid continuously with last=1, after reset -> grant order 0,1,2,0,1,2; rf_we high every cycle.
- Burst lock: req1 issues 3 beats (addr 9,10,11, last on 3rd) while req0/req2 valid -> only req1 ready for all 3 beats; then req2 granted, then req0.
- Timeout: req2 beat with last=0, then valid low for 16 cycles while req0 valid -> burst_abort pulses once; req0 granted the cycle after the abort; no rf_we during the idle gap.
- Drop to $0: 300 accepted writes to addr 0 -> rf_we never high; drop_cnt saturates at 255.
- Async reset mid-burst: assert rst_n=0 between clock edges while rf_we=1 -> rf_we, hazard_mask and drop_cnt go to 0 immediately; after release, state IDLE and req0 has priority.
